// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB result entry type, default widths and round-robin helper
package cdb_pkg;

    localparam int CDB_TAG_WIDTH  = 4;
    localparam int CDB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [CDB_TAG_WIDTH-1:0]  tag;
        logic [CDB_DATA_WIDTH-1:0] data;
    } cdb_entry_t;

    function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
        return (w + 1 >= n) ? 0 : w + 1;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source {tag, data} result queue with registered count
module cdb_src_fifo
#(
    parameter int TAG_WIDTH  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int QDEPTH     = 2,
    localparam int PTR_W     = $clog2(QDEPTH),
    localparam int CNT_W     = $clog2(QDEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [TAG_WIDTH-1:0]  i_push_tag,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [CNT_W-1:0]      o_count,
    output logic [TAG_WIDTH-1:0]  o_head_tag,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic                  o_empty
);

    logic [TAG_WIDTH+DATA_WIDTH-1:0] r_mem [QDEPTH];
    logic [PTR_W-1:0]                r_wr_ptr;
    logic [PTR_W-1:0]                r_rd_ptr;
    logic [CNT_W-1:0]                r_count;
    logic                            w_full;
    logic                            w_do_push;
    logic                            w_do_pop;

    assign w_full  = (r_count == CNT_W'(QDEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // A full queue never accepts, even if it pops on the same edge.
    assign w_do_push = i_push && !w_full && rst_n && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && rst_n && !i_flush;

    assign {o_head_tag, o_head_data} = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= {i_push_tag, i_push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter over per-FU result queues
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int TAG_WIDTH  = CDB_TAG_WIDTH,
    parameter int DATA_WIDTH = CDB_DATA_WIDTH,
    parameter int QDEPTH     = 2,
    localparam int SRC_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [NUM_FU-1:0]            fu_valid,
    output logic [NUM_FU-1:0]            fu_ready,
    input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data,
    output logic                         cdb_valid,
    output logic [TAG_WIDTH-1:0]         cdb_tag,
    output logic [DATA_WIDTH-1:0]        cdb_data,
    output logic [SRC_W-1:0]             cdb_src
);

    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [CNT_W-1:0]      w_count     [NUM_FU];
    logic [TAG_WIDTH-1:0]  w_head_tag  [NUM_FU];
    logic [DATA_WIDTH-1:0] w_head_data [NUM_FU];
    logic [NUM_FU-1:0]     w_empty;
    logic [NUM_FU-1:0]     w_push;
    logic [NUM_FU-1:0]     w_pop;
    logic                  w_grant_valid;
    logic [SRC_W-1:0]      w_grant_idx;
    logic [SRC_W:0]        w_scan_idx;

    logic [SRC_W-1:0]      r_rr_ptr;
    logic                  r_cdb_valid;
    logic [TAG_WIDTH-1:0]  r_cdb_tag;
    logic [DATA_WIDTH-1:0] r_cdb_data;
    logic [SRC_W-1:0]      r_cdb_src;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_src
        assign fu_ready[i] = (w_count[i] < CNT_W'(QDEPTH)) && rst_n && !flush;
        assign w_push[i]   = fu_valid[i] && fu_ready[i];
        assign w_pop[i]    = w_grant_valid && (w_grant_idx == SRC_W'(i)) && rst_n && !flush;

        cdb_src_fifo #(
            .TAG_WIDTH  (TAG_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .QDEPTH     (QDEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_flush     (flush),
            .i_push      (w_push[i]),
            .i_push_tag  (fu_tag[i*TAG_WIDTH +: TAG_WIDTH]),
            .i_push_data (fu_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .i_pop       (w_pop[i]),
            .o_count     (w_count[i]),
            .o_head_tag  (w_head_tag[i]),
            .o_head_data (w_head_data[i]),
            .o_empty     (w_empty[i])
        );
    end

    // Scan from rr_ptr upward, wrapping; first non-empty queue wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            w_scan_idx = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (w_scan_idx >= (SRC_W+1)'(NUM_FU)) begin
                w_scan_idx = w_scan_idx - (SRC_W+1)'(NUM_FU);
            end
            if (!w_grant_valid && !w_empty[w_scan_idx[SRC_W-1:0]]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_scan_idx[SRC_W-1:0];
            end
        end
    end

    // Flush drops the broadcast but keeps rr_ptr and the last tag/data/src.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
            r_cdb_src   <= '0;
            r_rr_ptr    <= '0;
        end else if (flush) begin
            r_cdb_valid <= 1'b0;
        end else if (w_grant_valid) begin
            r_cdb_valid <= 1'b1;
            r_cdb_tag   <= w_head_tag[w_grant_idx];
            r_cdb_data  <= w_head_data[w_grant_idx];
            r_cdb_src   <= w_grant_idx;
            r_rr_ptr    <= SRC_W'(rr_next(32'(w_grant_idx), NUM_FU));
        end else begin
            r_cdb_valid <= 1'b0;
        end
    end

    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed table-driven bench for cdb_arbiter
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [3:0]   fu_valid;
    logic [3:0]   fu_ready;
    logic [15:0]  fu_tag;
    logic [127:0] fu_data;
    logic         cdb_valid;
    logic [3:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic [1:0]   cdb_src;

    cdb_arbiter #(
        .NUM_FU     (4),
        .TAG_WIDTH  (4),
        .DATA_WIDTH (32),
        .QDEPTH     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_ready  (fu_ready),
        .fu_tag    (fu_tag),
        .fu_data   (fu_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic [3:0]  valid;
        logic [15:0] tags;
        logic [3:0]  exp_ready;
        logic        exp_v;
        logic [3:0]  exp_tag;
        logic [1:0]  exp_src;
    } vec_t;

    vec_t       tbl[$];
    int         n_vec = 0;
    int         n_err = 0;
    cdb_entry_t held;

    function automatic logic [31:0] mkdata(input logic [1:0] src, input logic [3:0] tag);
        return {8'hC0, 6'd0, src, 12'd0, tag};
    endfunction

    function automatic void add(input logic f, input logic [3:0] v, input logic [15:0] t,
                                input logic [3:0] r, input logic ev, input logic [3:0] et,
                                input logic [1:0] es);
        vec_t x;
        x.flush = f; x.valid = v; x.tags = t; x.exp_ready = r;
        x.exp_v = ev; x.exp_tag = et; x.exp_src = es;
        tbl.push_back(x);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [15:0] t);
        fu_valid = v;
        fu_tag   = t;
        for (int i = 0; i < 4; i++) begin
            fu_data[i*32 +: 32] = mkdata(2'(i), t[i*4 +: 4]);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_data = '0;

        // contention: all four push at once, rr_ptr=0
        add(0, 4'b1111, 16'h7654, 4'b1111, 0, 4'h0, 2'd0);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h4, 2'd0);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h5, 2'd1);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h6, 2'd2);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h7, 2'd3);
        add(0, 4'b0000, 16'h0000, 4'b1111, 0, 4'h7, 2'd3);
        // fairness: FU0 and FU3 continuously valid
        add(0, 4'b1001, 16'h9001, 4'b1111, 0, 4'h7, 2'd3);
        add(0, 4'b1001, 16'hA002, 4'b1111, 1, 4'h1, 2'd0);
        add(0, 4'b1001, 16'hB003, 4'b0111, 1, 4'h9, 2'd3);
        add(0, 4'b1001, 16'hB004, 4'b1110, 1, 4'h2, 2'd0);
        add(0, 4'b1001, 16'hC004, 4'b0111, 1, 4'hA, 2'd3);
        add(0, 4'b1001, 16'hC005, 4'b1110, 1, 4'h3, 2'd0);
        add(0, 4'b1001, 16'hD005, 4'b0111, 1, 4'hB, 2'd3);
        add(0, 4'b0000, 16'h0000, 4'b1110, 1, 4'h4, 2'd0);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'hC, 2'd3);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h5, 2'd0);
        add(0, 4'b0000, 16'h0000, 4'b1111, 0, 4'h5, 2'd0);
        // FU1 alone, three back-to-back: drain keeps pace
        add(0, 4'b0010, 16'h0010, 4'b1111, 0, 4'h5, 2'd0);
        add(0, 4'b0010, 16'h0020, 4'b1111, 1, 4'h1, 2'd1);
        add(0, 4'b0010, 16'h0030, 4'b1111, 1, 4'h2, 2'd1);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h3, 2'd1);
        add(0, 4'b0000, 16'h0000, 4'b1111, 0, 4'h3, 2'd1);
        // FU0 and FU1 both streaming: queues fill and ready drops at count 2
        add(0, 4'b0011, 16'h0011, 4'b1111, 0, 4'h3, 2'd1);
        add(0, 4'b0011, 16'h0022, 4'b1111, 1, 4'h1, 2'd0);
        add(0, 4'b0011, 16'h0033, 4'b1101, 1, 4'h1, 2'd1);
        add(0, 4'b0011, 16'h0034, 4'b1110, 1, 4'h2, 2'd0);
        add(0, 4'b0011, 16'h0044, 4'b1101, 1, 4'h2, 2'd1);
        add(0, 4'b0000, 16'h0000, 4'b1110, 1, 4'h3, 2'd0);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h3, 2'd1);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h4, 2'd0);
        add(0, 4'b0000, 16'h0000, 4'b1111, 0, 4'h4, 2'd0);
        // flush with five queued; rr_ptr survives the flush
        add(0, 4'b1111, 16'hBA98, 4'b1111, 0, 4'h4, 2'd0);
        add(0, 4'b0011, 16'h00DC, 4'b1111, 1, 4'h9, 2'd1);
        add(1, 4'b1111, 16'h6666, 4'b0000, 0, 4'h9, 2'd1);
        add(0, 4'b0000, 16'h0000, 4'b1111, 0, 4'h9, 2'd1);
        add(0, 4'b0110, 16'h0320, 4'b1111, 0, 4'h9, 2'd1);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h3, 2'd2);
        add(0, 4'b0000, 16'h0000, 4'b1111, 1, 4'h2, 2'd1);
        add(0, 4'b0000, 16'h0000, 4'b1111, 0, 4'h2, 2'd1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(cdb_valid), 32'd0);
        chk("rst_tag",   32'(cdb_tag),   32'd0);
        chk("rst_data",  cdb_data,       32'd0);
        chk("rst_src",   32'(cdb_src),   32'd0);
        chk("rst_ready", 32'(fu_ready),  32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(fu_ready), 32'hF);

        // single result from FU2
        fu_valid = 4'b0100;
        fu_tag[11:8] = 4'd5;
        fu_data[95:64] = 32'hDEADBEEF;
        @(posedge clk); #1;
        fu_valid = '0;
        chk("single_t0_valid", 32'(cdb_valid), 32'd0);
        @(posedge clk); #1;
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_tag",   32'(cdb_tag),   32'd5);
        chk("single_data",  cdb_data,       32'hDEADBEEF);
        chk("single_src",   32'(cdb_src),   32'd2);
        @(posedge clk); #1;
        chk("single_after_valid", 32'(cdb_valid), 32'd0);
        chk("single_after_tag",   32'(cdb_tag),   32'd5);

        // reset mid-stream with three results queued
        drive(4'b0111, 16'h0321);
        @(posedge clk); #1;
        drive(4'b0000, 16'h0000);
        chk("mid_push_valid", 32'(cdb_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(fu_ready), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_valid", 32'(cdb_valid), 32'd0);
        chk("mid_rst_tag",   32'(cdb_tag),   32'd0);
        chk("mid_rst_data",  cdb_data,       32'd0);
        chk("mid_rst_src",   32'(cdb_src),   32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_idle%0d_valid", c), 32'(cdb_valid), 32'd0);
            chk($sformatf("mid_idle%0d_tag", c),   32'(cdb_tag),   32'd0);
        end

        held.tag  = '0;
        held.data = '0;
        for (int i = 0; i < tbl.size(); i++) begin
            flush = tbl[i].flush;
            drive(tbl[i].valid, tbl[i].tags);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(fu_ready), 32'(tbl[i].exp_ready));
            @(posedge clk); #1;
            if (tbl[i].exp_v) begin
                held.tag  = tbl[i].exp_tag;
                held.data = mkdata(tbl[i].exp_src, tbl[i].exp_tag);
            end
            chk($sformatf("v%0d_valid", i), 32'(cdb_valid), 32'(tbl[i].exp_v));
            chk($sformatf("v%0d_tag", i),   32'(cdb_tag),   32'(tbl[i].exp_tag));
            chk($sformatf("v%0d_data", i),  cdb_data,       held.data);
            chk($sformatf("v%0d_src", i),   32'(cdb_src),   32'(tbl[i].exp_src));
        end
        flush = 1'b0;
        drive(4'b0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, number of functional-unit result sources.
REQ-002 Parameter TAG_WIDTH, default 4, ROB tag width.
REQ-003 Parameter DATA_WIDTH, default 32, result data width.
REQ-004 Parameter QDEPTH, default 2, per-source result queue depth; power of two, at least 2.
REQ-005 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 flush  input  1  squash all pending results.
REQ-008 fu_valid  input  NUM_FU  per-source result-valid.
REQ-009 fu_ready  output  NUM_FU  per-source accept.
REQ-010 fu_tag  input  NUM_FU x TAG_WIDTH  per-source ROB tag.
REQ-011 fu_data  input  NUM_FU x DATA_WIDTH  per-source result value.
REQ-012 cdb_valid  output  1  broadcast valid; consumed by the ROB and reservation stations.
REQ-013 cdb_tag  output  TAG_WIDTH  broadcast tag.
REQ-014 cdb_data  output  DATA_WIDTH  broadcast value.
REQ-015 cdb_src  output  clog2(NUM_FU)  index of the winning source.

Function
REQ-016 Each source SHALL own a FIFO of QDEPTH {tag, data} entries.
REQ-017 fu_ready[i] SHALL equal (count[i] < QDEPTH) AND rst_n AND NOT flush, as a combinational function of registered count.
REQ-018 A transfer on source i SHALL occur when fu_valid[i] and fu_ready[i] are both high at a clock edge; a push into a full FIFO SHALL never occur, even when that FIFO pops in the same cycle.
REQ-019 Arbitration SHALL be combinational over non-empty FIFOs, round-robin, starting search at pointer rr_ptr.
REQ-020 The winner's head entry SHALL pop at the edge, and cdb_valid/cdb_tag/cdb_data/cdb_src SHALL be registered from it.
REQ-021 Minimum latency SHALL be: accept at edge t, visible on the CDB in the cycle after edge t+1.
REQ-022 Exactly one broadcast SHALL occur per cycle at most.
REQ-023 cdb_valid SHALL be 0 in any cycle following an edge at which no FIFO was non-empty; cdb_tag, cdb_data and cdb_src SHALL then hold their previous values.
REQ-024 After a grant to source w, rr_ptr SHALL become (w+1) mod NUM_FU; with no grant, rr_ptr SHALL be unchanged.
REQ-025 Per-source order SHALL be preserved (FIFO); no ordering SHALL be guaranteed across sources.
REQ-026 Simultaneous push and pop on the same FIFO SHALL leave count unchanged.
REQ-027 Read and write pointers SHALL wrap modulo QDEPTH.
REQ-028 A source with a continuously non-empty FIFO SHALL be granted within NUM_FU cycles (starvation-free).
REQ-029 On flush high at an edge: all counts and pointers SHALL be cleared, no push or pop SHALL occur, and cdb_valid SHALL be 0 next cycle; rr_ptr SHALL be unchanged.

Reset
REQ-030 With rst_n low at an edge: all FIFO counts and pointers SHALL be 0, rr_ptr SHALL be 0, cdb_valid SHALL be 0, and cdb_tag, cdb_data and cdb_src SHALL be 0.
REQ-031 fu_ready SHALL be 0 while rst_n is low.
REQ-032 Reset asserted mid-operation SHALL discard all queued results, with no broadcast in the following cycle.
REQ-033 FIFO storage arrays need not be reset.

Structure
REQ-034 Shared package cdb_pkg SHALL hold cdb_entry_t {tag, data} and the default constants for TAG_WIDTH and DATA_WIDTH; the ROB and reservation stations SHALL use the same package.
REQ-035 Per-source queue SHALL be a sub-module cdb_src_fifo (push/pop/count/head), instantiated NUM_FU times by generate.
REQ-036 Arbiter and output register SHALL live in cdb_arbiter.

Verification
REQ-037 Single result: after reset, FU2 presents tag 5, data 0xDEADBEEF for one cycle -> cdb_valid=1, tag 5, data 0xDEADBEEF, src 2 for exactly one cycle, two edges after the accept.
REQ-038 Contention: all four FUs push one result in the same cycle, rr_ptr=0 -> broadcasts in src order 0,1,2,3 on consecutive cycles, then cdb_valid=0.
REQ-039 Backpressure: FU1 pushes 3 back-to-back results with no other traffic -> fu_ready[1] never drops (drain keeps pace), broadcasts in push order; with QDEPTH=2 and FU0 always full, fu_ready[1] drops to 0 when count[1]=2.
REQ-040 Fairness: FU0 and FU3 continuously valid -> grants alternate 0,3,0,3; no source waits more than 4 cycles.
REQ-041 Flush: FIFOs hold 5 results, flush pulses -> cdb_valid=0 next cycle, none of the 5 tags ever broadcast, and a new push afterward broadcasts normally.
REQ-042 Reset mid-stream: rst_n low for one edge while 3 results are queued -> all outputs 0, fu_ready=0 during reset, no stale tag appears afterward.
